// File: rtl/gpr_pkg.sv
// Shared constants and packed-slice helpers for the GPR bank and its read ports.
// Port i of a packed bus occupies bits [i*W +: W].
package gpr_pkg;

    localparam int GPR_ZERO         = 0;
    localparam int GPR_DW_DEFAULT   = 32;
    localparam int GPR_NREG_DEFAULT = 32;

    // LSB of read port's select field inside the packed rsel bus
    function automatic int sel_lsb(input int port, input int aw);
        return port * aw;
    endfunction

    // LSB of read port's data field inside the packed rdata bus
    function automatic int data_lsb(input int port, input int dw);
        return port * dw;
    endfunction

endpackage

// File: rtl/gpr_read_port.sv
// One combinational read port: register mux, r0 forced to zero, optional
// same-cycle write forwarding and scoreboard busy qualification.
module gpr_read_port
    import gpr_pkg::*;
#(
    parameter int DW      = GPR_DW_DEFAULT,
    parameter int NREG    = GPR_NREG_DEFAULT,
    parameter int AW      = $clog2(NREG),
    parameter int BYPASS  = 1,
    parameter int SCOREBD = 1
)(
    input  logic            rst,
    input  logic [DW-1:0]   mem [NREG],
    input  logic [NREG-1:0] busy_vec,
    input  logic            we,
    input  logic [AW-1:0]   wsel,
    input  logic [DW-1:0]   wdata,
    input  logic [AW-1:0]   rsel,
    output logic [DW-1:0]   rdata,
    output logic            rd_busy
);

    logic fwd_hit;

    // A write that lands this cycle makes the pending value visible now
    assign fwd_hit = (BYPASS != 0) && we && (wsel == rsel);

    always_comb begin
        rdata   = '0;
        rd_busy = 1'b0;
        if (!rst && (rsel != AW'(GPR_ZERO))) begin
            rdata   = fwd_hit ? wdata : mem[rsel];
            rd_busy = (SCOREBD != 0) && busy_vec[rsel] && !fwd_hit;
        end
    end

endmodule

// File: rtl/gpr_bank_sb.sv
// Parametrised GPR file: synchronous write, reset clear, NRD read ports with
// optional bypass, and a one-bit-per-register pending-write scoreboard.
module gpr_bank_sb
    import gpr_pkg::*;
#(
    parameter int DW      = GPR_DW_DEFAULT,
    parameter int NREG    = GPR_NREG_DEFAULT,
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int SCOREBD = 1,
    parameter int DEBUG   = 0,
    localparam int AW     = $clog2(NREG)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     wsel,
    input  logic [DW-1:0]     wdata,
    input  logic [NRD*AW-1:0] rsel,
    output logic [NRD*DW-1:0] rdata,
    output logic [NRD-1:0]    rd_busy,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_dst,
    output logic [NREG-1:0]   busy_vec
);

    logic [DW-1:0] mem_reg [NREG];
    logic          wr_commit;

    assign wr_commit = we && (wsel != AW'(GPR_ZERO));

    // Full clear on reset keeps the storage X-free; r0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_commit) begin
            mem_reg[wsel] <= wdata;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if ((DEBUG != 0) && !rst && wr_commit) begin
            $display("R[%2d]=%8X", wsel, wdata);
        end
    end
`endif

    generate
        if (SCOREBD != 0) begin : g_sb
            logic [NREG-1:0] busy_reg;
            logic [NREG-1:0] busy_next;

            // Set is applied after clear: a new issue outranks an older writeback
            always_comb begin
                busy_next = busy_reg;
                if (wr_commit) begin
                    busy_next[wsel] = 1'b0;
                end
                if (iss_en && (iss_dst != AW'(GPR_ZERO))) begin
                    busy_next[iss_dst] = 1'b1;
                end
                busy_next[0] = 1'b0;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    busy_reg <= '0;
                end else begin
                    busy_reg <= busy_next;
                end
            end

            assign busy_vec = busy_reg;
        end else begin : g_nosb
            assign busy_vec = '0;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            gpr_read_port #(
                .DW      (DW),
                .NREG    (NREG),
                .AW      (AW),
                .BYPASS  (BYPASS),
                .SCOREBD (SCOREBD)
            ) u_port (
                .rst      (rst),
                .mem      (mem_reg),
                .busy_vec (busy_vec),
                .we       (we),
                .wsel     (wsel),
                .wdata    (wdata),
                .rsel     (rsel[sel_lsb(gi, AW) +: AW]),
                .rdata    (rdata[data_lsb(gi, DW) +: DW]),
                .rd_busy  (rd_busy[gi])
            );
        end
    endgenerate

endmodule
